// File: rtl/bsp_pkg.sv
// bsp_pkg: shared constants for the pipelined barrel shifter.
//   MODE_W            width of the per-transaction mode field
//   MODE_ROL..SRA     legal mode encodings; 3'b101..3'b111 are illegal
//   mode_is_legal()   true for the five defined modes
//   mode_is_shift()   true for SLL/SRL/SRA (modes that can lose bits)
package bsp_pkg;

  localparam int unsigned MODE_W = 3;

  localparam logic [MODE_W-1:0] MODE_ROL = 3'b000;
  localparam logic [MODE_W-1:0] MODE_ROR = 3'b001;
  localparam logic [MODE_W-1:0] MODE_SLL = 3'b010;
  localparam logic [MODE_W-1:0] MODE_SRL = 3'b011;
  localparam logic [MODE_W-1:0] MODE_SRA = 3'b100;

  function automatic logic mode_is_legal(input logic [MODE_W-1:0] mode);
    return (mode <= MODE_SRA);
  endfunction

  function automatic logic mode_is_shift(input logic [MODE_W-1:0] mode);
    return (mode == MODE_SLL) || (mode == MODE_SRL) || (mode == MODE_SRA);
  endfunction

endpackage

// File: rtl/barrel_shift_stage.sv
// barrel_shift_stage: one log2 stage of the barrel shifter. Moves the operand by 2^STAGE
// positions when amount bit STAGE is set (legal modes only), then registers the result together
// with the transaction's side-band fields. The register slice loads only when i_advance is high.
// Optional flag tracking is compiled in with BARREL_SHIFT_PIPE_FLAGS_EN.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   i_advance           global pipeline advance (load enable)
//   i_valid/data/amt/mode/tag   previous stage slice
//   i_carry, i_zero     previous stage flags (flags build only)
//   o_*                 this stage's registered slice
module barrel_shift_stage
  import bsp_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned STAGE = 0,
  parameter int unsigned TAG_W = 4,
  localparam int unsigned SHW = $clog2(WIDTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_advance,
  input  logic              i_valid,
  input  logic [WIDTH-1:0]  i_data,
  input  logic [SHW-1:0]    i_amt,
  input  logic [MODE_W-1:0] i_mode,
  input  logic [TAG_W-1:0]  i_tag,
`ifdef BARREL_SHIFT_PIPE_FLAGS_EN
  input  logic              i_carry,
  input  logic              i_zero,
  output logic              o_carry,
  output logic              o_zero,
`endif
  output logic              o_valid,
  output logic [WIDTH-1:0]  o_data,
  output logic [SHW-1:0]    o_amt,
  output logic [MODE_W-1:0] o_mode,
  output logic [TAG_W-1:0]  o_tag
);

  localparam int unsigned DIST = 2 ** STAGE;

  logic             w_move;
  logic             w_fill;
  logic [WIDTH-1:0] w_data;

  // Illegal modes never move, so they pass data through with carry left at 0.
  assign w_move = i_amt[STAGE] && mode_is_legal(i_mode);
  // Sign fill: MSB of the running value equals the original operand MSB under SRA.
  assign w_fill = (i_mode == MODE_SRA) ? i_data[WIDTH-1] : 1'b0;

  always_comb begin
    w_data = i_data;
    if (w_move) begin
      case (i_mode)
        MODE_ROL: w_data = {i_data[WIDTH-1-DIST:0], i_data[WIDTH-1:WIDTH-DIST]};
        MODE_ROR: w_data = {i_data[DIST-1:0], i_data[WIDTH-1:DIST]};
        MODE_SLL: w_data = {i_data[WIDTH-1-DIST:0], {DIST{1'b0}}};
        default:  w_data = {{DIST{w_fill}}, i_data[WIDTH-1:DIST]};  // SRL / SRA
      endcase
    end
  end

  logic             r_valid;
  logic [WIDTH-1:0] r_data;
  logic [SHW-1:0]   r_amt;
  logic [MODE_W-1:0] r_mode;
  logic [TAG_W-1:0] r_tag;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_amt   <= '0;
      r_mode  <= '0;
      r_tag   <= '0;
    end else if (i_advance) begin
      r_valid <= i_valid;
      r_data  <= w_data;
      r_amt   <= i_amt;
      r_mode  <= i_mode;
      r_tag   <= i_tag;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_amt   = r_amt;
  assign o_mode  = r_mode;
  assign o_tag   = r_tag;

`ifdef BARREL_SHIFT_PIPE_FLAGS_EN
  logic w_carry;
  logic w_zero;
  logic r_carry;
  logic r_zero;

  // Only a moving stage updates carry; the last mover wins.
  always_comb begin
    w_carry = i_carry;
    if (w_move) begin
      case (i_mode)
        MODE_ROL: w_carry = w_data[0];
        MODE_ROR: w_carry = w_data[WIDTH-1];
        MODE_SLL: w_carry = i_data[WIDTH-DIST];
        default:  w_carry = i_data[DIST-1];  // SRL / SRA
      endcase
    end
  end

  // Rotates and non-moving stages preserve zero-ness, so the compare is only needed on shifts.
  assign w_zero = (w_move && mode_is_shift(i_mode)) ? (w_data == '0) : i_zero;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_carry <= 1'b0;
      r_zero  <= 1'b0;
    end else if (i_advance) begin
      r_carry <= w_carry;
      r_zero  <= w_zero;
    end
  end

  assign o_carry = r_carry;
  assign o_zero  = r_zero;
`endif

endmodule

// File: rtl/barrel_shift_pipe.sv
// barrel_shift_pipe: fully pipelined WIDTH-bit rotator/shifter (ROL, ROR, SLL, SRL, SRA) with
// valid/ready on both sides. One register slice per log2 stage, latency SHW cycles, global stall.
// Build option BARREL_SHIFT_PIPE_FLAGS_EN adds out_zero/out_carry and the carry pipeline.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   in_valid/in_ready          input handshake (in_ready depends only on out_valid/out_ready)
//   in_data/in_amt/in_mode/in_tag   operand, amount, mode (see bsp_pkg), user tag
//   out_valid/out_ready        output handshake
//   out_data/out_tag           result and its tag
//   out_zero/out_carry         result == 0, last bit moved out (flags build only)
module barrel_shift_pipe
  import bsp_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned TAG_W = 4,
  localparam int unsigned SHW = $clog2(WIDTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_data,
  input  logic [SHW-1:0]    in_amt,
  input  logic [MODE_W-1:0] in_mode,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_data,
  output logic [TAG_W-1:0]  out_tag
`ifdef BARREL_SHIFT_PIPE_FLAGS_EN
  ,
  output logic              out_zero,
  output logic              out_carry
`endif
);

  // Index 0 is the input port, index k+1 is the output of stage k.
  logic              w_valid [SHW+1];
  logic [WIDTH-1:0]  w_data  [SHW+1];
  logic [SHW-1:0]    w_amt   [SHW+1];
  logic [MODE_W-1:0] w_mode  [SHW+1];
  logic [TAG_W-1:0]  w_tag   [SHW+1];
  logic              w_advance;

  // Whole pipe moves together; empty slots hold too, so bubbles are never collapsed.
  assign w_advance = !out_valid || out_ready;
  assign in_ready  = w_advance;

  assign w_valid[0] = in_valid;
  assign w_data[0]  = in_data;
  assign w_amt[0]   = in_amt;
  assign w_mode[0]  = in_mode;
  assign w_tag[0]   = in_tag;

`ifdef BARREL_SHIFT_PIPE_FLAGS_EN
  logic w_carry [SHW+1];
  logic w_zero  [SHW+1];

  assign w_carry[0] = 1'b0;
  assign w_zero[0]  = (in_data == '0);
`endif

  for (genvar k = 0; k < SHW; k++) begin : g_stage
    barrel_shift_stage #(
      .WIDTH (WIDTH),
      .STAGE (k),
      .TAG_W (TAG_W)
    ) u_stage (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_advance (w_advance),
      .i_valid   (w_valid[k]),
      .i_data    (w_data[k]),
      .i_amt     (w_amt[k]),
      .i_mode    (w_mode[k]),
      .i_tag     (w_tag[k]),
`ifdef BARREL_SHIFT_PIPE_FLAGS_EN
      .i_carry   (w_carry[k]),
      .i_zero    (w_zero[k]),
      .o_carry   (w_carry[k+1]),
      .o_zero    (w_zero[k+1]),
`endif
      .o_valid   (w_valid[k+1]),
      .o_data    (w_data[k+1]),
      .o_amt     (w_amt[k+1]),
      .o_mode    (w_mode[k+1]),
      .o_tag     (w_tag[k+1])
    );
  end

  assign out_valid = w_valid[SHW];
  assign out_data  = w_data[SHW];
  assign out_tag   = w_tag[SHW];

`ifdef BARREL_SHIFT_PIPE_FLAGS_EN
  assign out_carry = w_carry[SHW];
  assign out_zero  = w_zero[SHW];
`endif

  // Amount and mode are fully consumed by the last stage.
  logic w_unused;
  assign w_unused = ^{w_amt[SHW], w_mode[SHW]};

endmodule

// File: tb/tb_barrel_shift_pipe.sv
// tb_barrel_shift_pipe: directed self-checking bench for barrel_shift_pipe, WIDTH=16.
// Flag ports and flag checks are present when BARREL_SHIFT_PIPE_FLAGS_EN is defined.
module tb_barrel_shift_pipe;
  import bsp_pkg::*;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned TAG_W = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [WIDTH-1:0]  in_data = '0;
  logic [3:0]        in_amt = '0;
  logic [MODE_W-1:0] in_mode = '0;
  logic [TAG_W-1:0]  in_tag = '0;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [WIDTH-1:0]  out_data;
  logic [TAG_W-1:0]  out_tag;
`ifdef BARREL_SHIFT_PIPE_FLAGS_EN
  logic              out_zero;
  logic              out_carry;
`endif

  int n_pass = 0;
  int n_chk  = 0;
  int n_tx   = 0;
  int n_rx   = 0;
  logic acc;

  always #5 clk = ~clk;

  barrel_shift_pipe #(
    .WIDTH (WIDTH),
    .TAG_W (TAG_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_amt    (in_amt),
    .in_mode   (in_mode),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_tag   (out_tag)
`ifdef BARREL_SHIFT_PIPE_FLAGS_EN
    ,
    .out_zero  (out_zero),
    .out_carry (out_carry)
`endif
  );

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [2:0] m, input logic [15:0] d, input logic [3:0] a,
                      input logic [3:0] t);
    in_valid = 1'b1;
    in_mode  = m;
    in_data  = d;
    in_amt   = a;
    in_tag   = t;
    step();
    in_valid = 1'b0;
  endtask

  task automatic wait_out(input string name);
    int n = 0;
    while (!out_valid && n < 16) begin
      step();
      n++;
    end
    check({name, "_valid"}, 32'(out_valid), 32'd1);
  endtask

  task automatic run_one(input string name, input logic [2:0] m, input logic [15:0] d,
                         input logic [3:0] a, input logic [3:0] t, input logic [15:0] exp_d,
                         input logic exp_c, input logic exp_z);
    send(m, d, a, t);
    wait_out(name);
    check({name, "_data"}, 32'(out_data), 32'(exp_d));
    check({name, "_tag"}, 32'(out_tag), 32'(t));
`ifdef BARREL_SHIFT_PIPE_FLAGS_EN
    check({name, "_carry"}, 32'(out_carry), 32'(exp_c));
    check({name, "_zero"}, 32'(out_zero), 32'(exp_z));
`else
    check({name, "_flags_unused"}, 32'({exp_c, exp_z}), 32'({exp_c, exp_z}) & 32'h3);
`endif
    step();
  endtask

  initial begin
    // Reset state while rst_n is held low.
    #2;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_out_tag", 32'(out_tag), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    #10;
    rst_n = 1'b1;

    // ROL 0x8001 by 1: presented in cycle c, out_valid in cycle c+4 (three edges after accept).
    send(MODE_ROL, 16'h8001, 4'd1, 4'h3);
    step();
    step();
    check("rol_lat_early", 32'(out_valid), 32'd0);
    step();
    check("rol_lat_valid", 32'(out_valid), 32'd1);
    check("rol_data", 32'(out_data), 32'h0003);
    check("rol_tag", 32'(out_tag), 32'h3);
`ifdef BARREL_SHIFT_PIPE_FLAGS_EN
    check("rol_carry", 32'(out_carry), 32'd1);
    check("rol_zero", 32'(out_zero), 32'd0);
`endif
    step();
    check("rol_drained", 32'(out_valid), 32'd0);

    run_one("sra_neg", MODE_SRA, 16'h8000, 4'd15, 4'h1, 16'hFFFF, 1'b0, 1'b0);
    run_one("sra_pos", MODE_SRA, 16'h4000, 4'd15, 4'h2, 16'h0000, 1'b1, 1'b1);
    run_one("srl_one", MODE_SRL, 16'h0001, 4'd1, 4'h4, 16'h0000, 1'b1, 1'b1);
    run_one("sll_zero_amt", MODE_SLL, 16'h00F0, 4'd0, 4'h5, 16'h00F0, 1'b0, 1'b0);
    run_one("illegal", 3'b101, 16'h1234, 4'd5, 4'h6, 16'h1234, 1'b0, 1'b0);
    run_one("ror_mid", MODE_ROR, 16'h00F1, 4'd4, 4'h7, 16'h100F, 1'b0, 1'b0);

    // Stream tags 0..7 (SLL 1 by tag) with out_ready low in cycles 6..8.
    n_tx = 0;
    n_rx = 0;
    for (int cyc = 0; cyc < 40 && n_rx < 8; cyc++) begin
      out_ready = !(cyc >= 6 && cyc <= 8);
      in_valid  = (n_tx < 8);
      in_mode   = MODE_SLL;
      in_data   = 16'h0001;
      in_amt    = 4'(n_tx);
      in_tag    = 4'(n_tx);
      @(negedge clk);
      if (!out_ready) begin
        check("stall_in_ready", 32'(in_ready), 32'd0);
        check("stall_valid", 32'(out_valid), 32'd1);
        check("stall_tag", 32'(out_tag), 32'(n_rx));
        check("stall_data", 32'(out_data), 32'(16'd1 << n_rx));
      end
      if (out_valid && out_ready) begin
        check("stream_tag", 32'(out_tag), 32'(n_rx));
        check("stream_data", 32'(out_data), 32'(16'd1 << n_rx));
        n_rx++;
      end
      acc = in_valid && in_ready;
      step();
      if (acc) n_tx++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check("stream_count", 32'(n_rx), 32'd8);
    step();
    check("stream_no_dup", 32'(out_valid), 32'd0);

    // Fill the pipe with three transactions, hold the output, then reset mid-cycle.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_mode   = MODE_ROL;
    in_data   = 16'hFFFF;
    in_amt    = 4'd1;
    in_tag    = 4'hA;
    step();
    in_tag = 4'hB;
    step();
    in_tag = 4'hC;
    step();
    in_valid = 1'b0;
    step();
    step();
    check("pre_rst_valid", 32'(out_valid), 32'd1);
    check("pre_rst_data", 32'(out_data), 32'hFFFF);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_data", 32'(out_data), 32'd0);
    check("mid_rst_tag", 32'(out_tag), 32'd0);
    check("mid_rst_in_ready", 32'(in_ready), 32'd1);
`ifdef BARREL_SHIFT_PIPE_FLAGS_EN
    check("mid_rst_carry", 32'(out_carry), 32'd0);
    check("mid_rst_zero", 32'(out_zero), 32'd0);
`endif
    #1;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    run_one("post_rst_ror", MODE_ROR, 16'h0001, 4'd4, 4'h9, 16'h1000, 1'b0, 1'b0);
    check("post_rst_empty", 32'(out_valid), 32'd0);
    step();
    step();
    check("post_rst_dropped", 32'(out_valid), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/barrel_shift_pipe.md
# barrel_shift_pipe

- Parametrised, fully pipelined barrel shifter/rotator: WIDTH-bit operand, per-transaction mode and amount, valid/ready streaming on both sides.
- Next generation of the lab's 8-bit combinational rotate-left/right unit. Adds logical and arithmetic shifts, one register per log2 stage, backpressure, and a passthrough tag.
- Sits between the operand source and the ALU result mux in the datapath.

## Interface

Parameters:
- WIDTH, 16: operand width; power of two, >= 4.
- TAG_W, 4: width of the user tag carried alongside each operand.
- Derived localparam SHW = log2(WIDTH): amount width and pipeline depth.

Ports:
- clk  in  1: single clock, rising edge.
- rst_n  in  1: asynchronous, active-low reset.
- in_valid  in  1: input transaction valid.
- in_ready  out  1: block accepts input this cycle.
- in_data  in  WIDTH: operand.
- in_amt  in  SHW: shift/rotate amount, 0..WIDTH-1.
- in_mode  in  3: operation select, encodings in bsp_pkg.
- in_tag  in  TAG_W: opaque tag, returned unchanged.
- out_valid  out  1: result valid.
- out_ready  in  1: consumer accepts result.
- out_data  out  WIDTH: result.
- out_tag  out  TAG_W: tag of this result.
- out_zero  out  1: present only with BARREL_SHIFT_PIPE_FLAGS_EN. High when out_data == 0.
- out_carry  out  1: present only with BARREL_SHIFT_PIPE_FLAGS_EN. Last bit shifted or rotated out.

## Operation

- Modes: 000 ROL, 001 ROR, 010 SLL (zero fill), 011 SRL (zero fill), 100 SRA (sign fill from in_data[WIDTH-1]).
- Codes 101–111 are illegal. They pass in_data through unchanged and set carry = 0.
- Stage k (k = 0..SHW-1) moves the value by 2^k positions when amt[k] = 1; otherwise the value passes unchanged.
- Each stage register holds: valid, value, mode, remaining amount bits, tag, carry.
- Amount 0 in any mode gives result = operand and carry = 0.
- Carry update rules:
  - Updated only in stages that actually move the value. Stages are ordered by increasing k, so the last moving stage determines the final carry.
  - SLL: bit WIDTH-2^k of that stage's input.
  - SRL/SRA: bit 2^k-1 of that stage's input.
  - ROL: result[0]. ROR: result[WIDTH-1].
- Global-stall pipeline: advance = !out_valid || out_ready.
  - in_ready = advance, combinational. It must not depend on in_valid.
  - When advance = 1, every stage loads from its predecessor, and stage 0 loads in_valid.
  - When advance = 0, all stages hold, including empty slots.
- An input is accepted on any cycle with in_valid && in_ready.
- Bubbles are not collapsed. Order is strictly preserved.

## Timing

- Latency is SHW cycles from acceptance to out_valid, with no stall. WIDTH=16 gives 4 cycles.
- Throughput is 1 transaction per cycle while out_ready = 1.
- While out_valid && !out_ready: out_data, out_tag and the flags hold stable, and in_ready = 0.
- Reset:
  - Asserting rst_n low clears all stage valids, out_valid, out_data, out_tag, out_zero and out_carry to 0 immediately, including mid-operation. In-flight transactions are dropped.
  - in_ready = 1 while the pipe is empty after reset.
- On the first clock edge after rst_n deasserts, a valid input is accepted.
- No combinational path from in_* to out_*. The only combinational path is out_ready -> in_ready.

## Configuration

- BARREL_SHIFT_PIPE_FLAGS_EN defined: the out_zero and out_carry ports exist. Carry is tracked per stage, and zero is computed from the final stage value and registered with it.
- BARREL_SHIFT_PIPE_FLAGS_EN undefined: the ports and the carry pipeline are removed. Data/tag behaviour and latency are identical.

## Structure

- Package bsp_pkg holds:
  - Mode encodings MODE_ROL, MODE_ROR, MODE_SLL, MODE_SRL, MODE_SRA.
  - Mode width constant MODE_W = 3.
- Sub-module barrel_shift_stage:
  - Parameters WIDTH and STAGE.
  - Contains one combinational shift-by-2^STAGE plus its register slice.
  - Instantiated SHW times in a generate loop in barrel_shift_pipe.

## Test plan

All cases WIDTH=16, flags enabled.

- ROL 0x8001 by 1 -> 0x0003, carry 1, zero 0, out_valid 4 cycles after accept.
- SRA 0x8000 by 15 -> 0xFFFF, carry 0. SRA 0x4000 by 15 -> 0x0000, zero 1, carry 1.
- SRL 0x0001 by 1 -> 0x0000, zero 1, carry 1. SLL 0x00F0 by 0 -> 0x00F0, carry 0.
- Back-to-back stream of tags 0..7 with out_ready held low for 3 cycles mid-stream:
  - Outputs hold stable and in_ready = 0 during the stall.
  - All 8 results emerge in tag order with no loss or duplication.
- Illegal mode 101, data 0x1234, amount 5 -> 0x1234, carry 0.
- Assert rst_n low with 3 transactions in flight -> all outputs 0 at once. After release, a new ROR 0x0001 by 4 -> 0x1000.
